// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory-side copy engines.
// Latency: n/a (types, constants and a pure packing function).
// Backpressure: n/a.
package gpu_mem_pkg;

    localparam int VRAM_W_BITS = 10;
    localparam int VRAM_H_BITS = 9;
    localparam int BLOCK_PIX   = 16;
    localparam int ADR_BITS    = VRAM_H_BITS + VRAM_W_BITS - 4;

    // DDR-side command size codes
    localparam logic [1:0] SZ_32  = 2'd0;
    localparam logic [1:0] SZ_64  = 2'd1;
    localparam logic [1:0] SZ_256 = 2'd2;
    localparam logic [1:0] SZ_8   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PIX0,
        ST_PIX1,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // 32-byte block address: row in the high bits, 16-pixel column block low
    function automatic logic [ADR_BITS-1:0] pack_adr(input logic [VRAM_H_BITS-1:0] y,
                                                     input logic [VRAM_W_BITS-5:0] xblk);
        return {y, xblk};
    endfunction

endpackage

// File: rtl/gpu_mem_blockbuf.sv
// 16-lane pixel accumulator for one 32-byte VRAM block, with lane mask and block tag.
// Latency: a lane write is visible on data/mask/tag the cycle after wr.
// Backpressure: none; accept clears mask and tag valid, clr wipes everything.
// Ports: clk/rst_n; clr, wr, lane, pix, tag_in, accept in; data, mask, tag, tag_vld out.
module gpu_mem_blockbuf
    import gpu_mem_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        wr,
    input  logic [3:0]                  lane,
    input  logic [15:0]                 pix,
    input  logic [ADR_BITS-1:0]         tag_in,
    input  logic                        accept,
    output logic [BLOCK_PIX*16-1:0]     data,
    output logic [BLOCK_PIX-1:0]        mask,
    output logic [ADR_BITS-1:0]         tag,
    output logic                        tag_vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            mask    <= '0;
            tag     <= '0;
            tag_vld <= 1'b0;
        end else if (clr) begin
            data    <= '0;
            mask    <= '0;
            tag     <= '0;
            tag_vld <= 1'b0;
        end else begin
            // Unmasked lanes keep stale data; the write mask hides them.
            if (accept) begin
                mask    <= '0;
                tag_vld <= 1'b0;
            end
            if (wr) begin
                data[{lane, 4'b0000} +: 16] <= pix;
                mask[lane]                  <= 1'b1;
                tag                         <= tag_in;
                tag_vld                     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_mem_cpuvram.sv
// CPU->VRAM rectangle copy: pops pixel pairs, packs them into 32-byte blocks, issues masked 256-bit writes.
// Latency: 1 FETCH + 2 PIX cycles per word; a block write is issued when the block changes or the rectangle ends.
// Backpressure: i_busy holds FLUSH with request fields stable; empty input FIFO stalls in FETCH.
// Ports: i_clk, i_nrst; start/geometry (i_activate, RegX0/Y0, RegSizeW/H, i_forceMask);
//        FIFO (i_inFIFO_empty, i_pairPixelFromCPU, o_readFIFOIn); status (o_active, o_exitSig);
//        memory command (o_command, i_busy, o_commandSize, o_write, o_adr, o_subadr, o_writeMask, o_dataOut).
// Build option: GPU_CPUVRAM_FORCEMASK_EN enables OR-ing i_forceMask into pixel bit 15.
module gpu_mem_cpuvram
    import gpu_mem_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_activate,
    input  logic signed [11:0]   RegX0,
    input  logic signed [11:0]   RegY0,
    input  logic [10:0]          RegSizeW,
    input  logic [9:0]           RegSizeH,
    input  logic                 i_forceMask,
    input  logic                 i_inFIFO_empty,
    input  logic [31:0]          i_pairPixelFromCPU,
    output logic                 o_readFIFOIn,
    output logic                 o_active,
    output logic                 o_exitSig,
    output logic                 o_command,
    input  logic                 i_busy,
    output logic [1:0]           o_commandSize,
    output logic                 o_write,
    output logic [14:0]          o_adr,
    output logic [2:0]           o_subadr,
    output logic [15:0]          o_writeMask,
    output logic [255:0]         o_dataOut
);

    state_t                  state, state_nxt;
    state_t                  ret_state, ret_nxt;
    logic [VRAM_W_BITS-1:0]  x0, w_m1, cnt_x;
    logic [VRAM_H_BITS-1:0]  y0, h_m1, cnt_y;
    logic [31:0]             word;

    logic [VRAM_W_BITS-1:0]  x_cur;
    logic [VRAM_H_BITS-1:0]  y_cur;
    logic [ADR_BITS-1:0]     cur_tag;
    logic [15:0]             pix_raw, pix_val;
    logic                    in_pix, conflict, pix_wr, last, accept, start, pop;

    logic [255:0]            buf_data;
    logic [15:0]             buf_mask;
    logic [ADR_BITS-1:0]     buf_tag;
    logic                    buf_tag_vld;

    // Only the low coordinate/size bits matter; the rest wrap away.
    logic unused_bits;
    assign unused_bits = ^{RegX0[11:10], RegY0[11:9], RegSizeW[10], RegSizeH[9]};

    assign x_cur    = x0 + cnt_x;
    assign y_cur    = y0 + cnt_y;
    assign cur_tag  = pack_adr(y_cur, x_cur[VRAM_W_BITS-1:4]);
    assign in_pix   = (state == ST_PIX0) || (state == ST_PIX1);
    assign conflict = buf_tag_vld && (buf_tag != cur_tag);
    assign pix_wr   = in_pix && !conflict;
    assign last     = (cnt_x == w_m1) && (cnt_y == h_m1);
    assign accept   = (state == ST_FLUSH) && !i_busy;
    // DONE also accepts a start so a back-to-back activate is not lost.
    assign start    = i_activate && ((state == ST_IDLE) || (state == ST_DONE));
    assign pop      = (state == ST_FETCH) && !i_inFIFO_empty;
    assign pix_raw  = (state == ST_PIX1) ? word[31:16] : word[15:0];

`ifdef GPU_CPUVRAM_FORCEMASK_EN
    assign pix_val = pix_raw | {i_forceMask, 15'd0};
`else
    logic unused_force;
    assign unused_force = i_forceMask;
    assign pix_val      = pix_raw;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            x0        <= '0;
            y0        <= '0;
            w_m1      <= '0;
            h_m1      <= '0;
            cnt_x     <= '0;
            cnt_y     <= '0;
            word      <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            if (start) begin
                x0    <= RegX0[VRAM_W_BITS-1:0];
                y0    <= RegY0[VRAM_H_BITS-1:0];
                // size 0 wraps to the full 1024 / 512
                w_m1  <= RegSizeW[VRAM_W_BITS-1:0] - 10'd1;
                h_m1  <= RegSizeH[VRAM_H_BITS-1:0] - 9'd1;
                cnt_x <= '0;
                cnt_y <= '0;
            end else if (pix_wr) begin
                if (cnt_x == w_m1) begin
                    cnt_x <= '0;
                    cnt_y <= cnt_y + 9'd1;
                end else begin
                    cnt_x <= cnt_x + 10'd1;
                end
            end
            if (pop) begin
                word <= i_pairPixelFromCPU;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (pop) state_nxt = ST_PIX0;
            end
            ST_PIX0, ST_PIX1: begin
                if (conflict) begin
                    // flush the old block, then retry this same pixel
                    state_nxt = ST_FLUSH;
                    ret_nxt   = state;
                end else if (last) begin
                    // an odd final pixel in PIX0 ends here; the upper half is dropped
                    state_nxt = ST_FLUSH;
                    ret_nxt   = ST_DONE;
                end else begin
                    state_nxt = (state == ST_PIX0) ? ST_PIX1 : ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (!i_busy) state_nxt = ret_state;
            end
            ST_DONE: begin
                state_nxt = start ? ST_FETCH : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    gpu_mem_blockbuf u_blockbuf (
        .clk     (i_clk),
        .rst_n   (i_nrst),
        .clr     (start),
        .wr      (pix_wr),
        .lane    (x_cur[3:0]),
        .pix     (pix_val),
        .tag_in  (cur_tag),
        .accept  (accept),
        .data    (buf_data),
        .mask    (buf_mask),
        .tag     (buf_tag),
        .tag_vld (buf_tag_vld)
    );

    assign o_readFIFOIn  = pop;
    assign o_active      = (state != ST_IDLE) && (state != ST_DONE);
    assign o_exitSig     = (state == ST_DONE);
    assign o_command     = (state == ST_FLUSH);
    assign o_write       = o_command;
    assign o_commandSize = o_command ? SZ_256 : 2'd0;
    assign o_adr         = o_command ? buf_tag : '0;
    assign o_subadr      = 3'd0;
    assign o_writeMask   = o_command ? buf_mask : '0;
    assign o_dataOut     = o_command ? buf_data : '0;

endmodule

// File: tb/tb_gpu_mem_cpuvram.sv
// Directed bench for gpu_mem_cpuvram: FIFO source model, write capture, hand-computed block contents.
// Latency: n/a.
// Backpressure: i_busy stalls and FIFO empty gaps are injected per test.
module tb_gpu_mem_cpuvram;

    logic               i_clk = 1'b0;
    logic               i_nrst;
    logic               i_activate;
    logic signed [11:0] RegX0, RegY0;
    logic [10:0]        RegSizeW;
    logic [9:0]         RegSizeH;
    logic               i_forceMask;
    logic               i_inFIFO_empty;
    logic [31:0]        i_pairPixelFromCPU;
    logic               o_readFIFOIn, o_active, o_exitSig, o_command, o_write;
    logic               i_busy;
    logic [1:0]         o_commandSize;
    logic [14:0]        o_adr;
    logic [2:0]         o_subadr;
    logic [15:0]        o_writeMask;
    logic [255:0]       o_dataOut;

    gpu_mem_cpuvram dut (
        .i_clk              (i_clk),
        .i_nrst             (i_nrst),
        .i_activate         (i_activate),
        .RegX0              (RegX0),
        .RegY0              (RegY0),
        .RegSizeW           (RegSizeW),
        .RegSizeH           (RegSizeH),
        .i_forceMask        (i_forceMask),
        .i_inFIFO_empty     (i_inFIFO_empty),
        .i_pairPixelFromCPU (i_pairPixelFromCPU),
        .o_readFIFOIn       (o_readFIFOIn),
        .o_active           (o_active),
        .o_exitSig          (o_exitSig),
        .o_command          (o_command),
        .i_busy             (i_busy),
        .o_commandSize      (o_commandSize),
        .o_write            (o_write),
        .o_adr              (o_adr),
        .o_subadr           (o_subadr),
        .o_writeMask        (o_writeMask),
        .o_dataOut          (o_dataOut)
    );

    initial forever #5 i_clk = ~i_clk;

    int vecs = 0;
    int errs = 0;

    logic [31:0]  fifo[$];
    logic [14:0]  wr_adr[$];
    logic [15:0]  wr_mask[$];
    logic [255:0] wr_data[$];

    int   cyc = 0, pops = 0, busy_left = 0, acc_cyc = 0, exit_cyc = 0, exit_cnt = 0;
    bit   gap_en = 0, pop_s = 0, stalled = 0;
    logic [14:0]  s_adr;
    logic [15:0]  s_mask;
    logic [255:0] s_data;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] lanes(input logic [15:0] m);
        logic [255:0] r = '0;
        for (int l = 0; l < 16; l++) r[l*16 +: 16] = m[l] ? 16'hFFFF : 16'h0000;
        return r;
    endfunction

    // n consecutive pixel values v0, v0+1, ... placed from lane first
    function automatic logic [255:0] blk(input int first, input int n, input int v0);
        logic [255:0] r = '0;
        for (int k = 0; k < n; k++) r[(first+k)*16 +: 16] = 16'(v0 + k);
        return r;
    endfunction

    task automatic drive_fifo();
        i_inFIFO_empty     = (fifo.size() == 0) || (gap_en && (cyc % 3 == 1));
        i_pairPixelFromCPU = (fifo.size() != 0) ? fifo[0] : 32'h0;
    endtask

    task automatic push_seq(input int base, input int nwords);
        for (int i = 0; i < nwords; i++)
            fifo.push_back({16'(base + 2*i + 1), 16'(base + 2*i)});
        drive_fifo();
    endtask

    // One clock: apply pops/stalls after the edge, sample outputs at the falling edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (pop_s) begin
            void'(fifo.pop_front());
            pops++;
        end
        pop_s = 0;
        if (o_command && busy_left > 0) begin
            i_busy = 1'b1;
            busy_left--;
        end else begin
            i_busy = 1'b0;
        end
        drive_fifo();
        @(negedge i_clk);
        cyc++;
        if (o_readFIFOIn) begin
            chk("pop_only_when_nonempty", i_inFIFO_empty, 0);
            pop_s = 1;
        end
        if (o_command) begin
            if (stalled) begin
                chk("stall_adr", o_adr, s_adr);
                chk("stall_mask", o_writeMask, s_mask);
                chk("stall_data", o_dataOut, s_data);
            end
            s_adr = o_adr; s_mask = o_writeMask; s_data = o_dataOut;
            stalled = i_busy;
            if (!i_busy) begin
                wr_adr.push_back(o_adr);
                wr_mask.push_back(o_writeMask);
                wr_data.push_back(o_dataOut);
                acc_cyc = cyc;
            end
        end else begin
            stalled = 0;
        end
        if (o_exitSig) begin
            exit_cnt++;
            exit_cyc = cyc;
        end
    endtask

    task automatic start(input logic [11:0] x, input logic [11:0] y, input logic [10:0] w, input logic [9:0] h);
        wr_adr.delete(); wr_mask.delete(); wr_data.delete();
        pops = 0; exit_cnt = 0;
        RegX0 = x; RegY0 = y; RegSizeW = w; RegSizeH = h;
        i_activate = 1'b1;
        tick();
        i_activate = 1'b0;
    endtask

    task automatic run(input string tag, input logic [11:0] x, input logic [11:0] y,
                       input logic [10:0] w, input logic [9:0] h);
        start(x, y, w, h);
        for (int i = 0; i < 3000 && exit_cnt == 0; i++) tick();
        chk({tag, "_exit_seen"}, exit_cnt, 1);
        chk({tag, "_exit_after_accept"}, exit_cyc, acc_cyc + 1);
        tick();
        chk({tag, "_exit_one_cycle"}, exit_cnt, 1);
        chk({tag, "_inactive"}, o_active, 0);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [14:0] adr,
                          input logic [15:0] mask, input logic [255:0] data);
        if (idx < wr_adr.size()) begin
            chk({tag, "_adr"}, wr_adr[idx], adr);
            chk({tag, "_mask"}, wr_mask[idx], mask);
            chk({tag, "_data"}, wr_data[idx] & lanes(mask), data & lanes(mask));
        end
    endtask

    logic [15:0] fm_lo, fm_hi;

    initial begin
        i_nrst = 1'b0; i_activate = 1'b0; RegX0 = '0; RegY0 = '0; RegSizeW = '0; RegSizeH = '0;
        i_forceMask = 1'b0; i_busy = 1'b0;
        drive_fifo();
        tick(); tick();
        chk("reset_outputs", {o_active, o_exitSig, o_command, o_readFIFOIn, o_write, o_commandSize,
                              o_adr, o_subadr, o_writeMask, o_dataOut}, 0);
        i_nrst = 1'b1;
        tick();

        // full aligned block
        push_seq(16'h1000, 8);
        run("t1", 12'd0, 12'd0, 11'd16, 10'd1);
        chk("t1_nwrites", wr_adr.size(), 1);
        chk("t1_pops", pops, 8);
        chk_wr("t1_w0", 0, 15'd0, 16'hFFFF, blk(0, 16, 16'h1000));

        // straddles two blocks
        push_seq(16'h2000, 8);
        run("t2", 12'd8, 12'd0, 11'd16, 10'd1);
        chk("t2_nwrites", wr_adr.size(), 2);
        chk_wr("t2_w0", 0, 15'd0, 16'hFF00, blk(8, 8, 16'h2000));
        chk_wr("t2_w1", 1, 15'd1, 16'h00FF, blk(0, 8, 16'h2008));

        // odd pixel count: third word must stay in the FIFO
        push_seq(16'h3000, 3);
        run("t3", 12'd0, 12'd0, 11'd3, 10'd1);
        chk("t3_pops", pops, 2);
        chk("t3_left", fifo.size(), 1);
        chk("t3_nwrites", wr_adr.size(), 1);
        chk_wr("t3_w0", 0, 15'd0, 16'h0007, blk(0, 3, 16'h3000));
        fifo.delete();
        drive_fifo();

        // wrap in X and Y using negative origins (-4 -> 1020, -1 -> 511)
        push_seq(16'h4000, 8);
        run("t4", 12'hFFC, 12'hFFF, 11'd8, 10'd2);
        chk("t4_nwrites", wr_adr.size(), 4);
        chk_wr("t4_w0", 0, 15'h7FFF, 16'hF000, blk(12, 4, 16'h4000));
        chk_wr("t4_w1", 1, 15'h7FC0, 16'h000F, blk(0, 4, 16'h4004));
        chk_wr("t4_w2", 2, 15'h003F, 16'hF000, blk(12, 4, 16'h4008));
        chk_wr("t4_w3", 3, 15'h0000, 16'h000F, blk(0, 4, 16'h400C));

        // arbiter stall plus FIFO gaps: same result as the first transfer
        gap_en = 1; busy_left = 5;
        push_seq(16'h1000, 8);
        run("t5", 12'd0, 12'd0, 11'd16, 10'd1);
        chk("t5_nwrites", wr_adr.size(), 1);
        chk("t5_pops", pops, 8);
        chk_wr("t5_w0", 0, 15'd0, 16'hFFFF, blk(0, 16, 16'h1000));
        gap_en = 0; busy_left = 0;

        // force-mask bit
        i_forceMask = 1'b1;
        fifo.push_back(32'h0ABC_1234);
        drive_fifo();
        run("t6", 12'd0, 12'd0, 11'd2, 10'd1);
`ifdef GPU_CPUVRAM_FORCEMASK_EN
        fm_lo = 16'h9234; fm_hi = 16'h8ABC;
`else
        fm_lo = 16'h1234; fm_hi = 16'h0ABC;
`endif
        chk("t6_nwrites", wr_adr.size(), 1);
        chk_wr("t6_w0", 0, 15'd0, 16'h0003, {224'd0, fm_hi, fm_lo});
        i_forceMask = 1'b0;

        // reset while a request is stalled in FLUSH
        busy_left = 10;
        push_seq(16'h5000, 8);
        start(12'd0, 12'd0, 11'd16, 10'd1);
        for (int i = 0; i < 200 && !o_command; i++) tick();
        chk("t7_in_flush", o_command, 1);
        i_nrst = 1'b0;
        #1;
        chk("t7_reset_outputs", {o_active, o_exitSig, o_command, o_readFIFOIn, o_write, o_commandSize,
                                 o_adr, o_subadr, o_writeMask, o_dataOut}, 0);
        busy_left = 0;
        tick();
        i_nrst = 1'b1;
        fifo.delete();
        pop_s = 0;
        drive_fifo();
        tick();
        push_seq(16'h6000, 8);
        run("t7b", 12'd0, 12'd0, 11'd16, 10'd1);
        chk("t7b_nwrites", wr_adr.size(), 1);
        chk_wr("t7b_w0", 0, 15'd0, 16'hFFFF, blk(0, 16, 16'h6000));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
